// File: rtl/inst_queue_issue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue (consumer end).
// Provides the instruction-queue entry layout, per-slot issue bundle, decode
// accept encodings and the helper that tells how many instructions an entry holds.
package inst_queue_issue_pkg;

   localparam int unsigned PC_W        = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned EXCP_W      = 7;
   localparam int unsigned EXCP_FLAG_W = 2;

   localparam logic [INST_W-1:0] INST_NOP = 32'h0340_0000;

   // Packed entry layout: {pc, pc_next, taken, inst0, inst1, badv, excp, excp_flag}
   typedef struct packed {
      logic [PC_W-1:0]        pc;
      logic [PC_W-1:0]        pc_next;
      logic                   taken;
      logic [INST_W-1:0]      inst0;
      logic [INST_W-1:0]      inst1;
      logic [PC_W-1:0]        badv;
      logic [EXCP_W-1:0]      excp;
      logic [EXCP_FLAG_W-1:0] excp_flag;
   } ifq_entry_t;

   localparam int unsigned ENTRY_W = $bits(ifq_entry_t);

   localparam ifq_entry_t ENTRY_RESET = '{pc: '0, pc_next: '0, taken: 1'b0,
                                          inst0: INST_NOP, inst1: INST_NOP,
                                          badv: '0, excp: '0, excp_flag: '0};

   // One issue slot as seen by decode
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   pc_next;
      logic              taken;
      logic [INST_W-1:0] inst;
   } ifq_slot_t;

   localparam ifq_slot_t SLOT_IDLE = '{pc: '0, pc_next: '0, taken: 1'b0, inst: INST_NOP};

   // Decode accept is thermometer coded
   typedef enum logic [1:0] {
      ACC_NONE = 2'b00,
      ACC_ONE  = 2'b01,
      ACC_TWO  = 2'b11
   } dec_accept_e;

   // An entry holds two instructions unless it is a single-instruction packet
   // (pc[2] set) or carries a fetch exception.
   function automatic logic entry_is_pair(input ifq_entry_t e);
      return (e.excp_flag == '0) && !e.pc[2];
   endfunction

endpackage

// File: rtl/inst_queue_issue_slot_pick.sv
// ifq_slot_pick: combinational issue-slot selection for the instruction queue.
// Inputs : head / head_nxt entries, rd_half (half of head to issue next), count.
// Outputs: slot0/slot1 bundles, slot0 exception info, out_valid, and the
//          read-pointer increment / next rd_half for accept 01 and accept 11.
module ifq_slot_pick
   import inst_queue_issue_pkg::*;
#(
   parameter int unsigned LOG_DEPTH = 3
) (
   input  ifq_entry_t             head,
   input  ifq_entry_t             head_nxt,
   input  logic                   rd_half,
   input  logic [LOG_DEPTH:0]     count,
   output ifq_slot_t              slot0,
   output ifq_slot_t              slot1,
   output logic [PC_W-1:0]        slot0_badv,
   output logic [EXCP_W-1:0]      slot0_excp,
   output logic                   slot0_excp_valid,
   output logic [1:0]             out_valid,
   output logic [1:0]             rd_inc_one,
   output logic                   rd_half_one,
   output logic [1:0]             rd_inc_two,
   output logic                   rd_half_two
);

   logic      head_pair, nxt_pair, head_excp, nxt_excp;
   logic      v0, v1, from_head, nxt_ok, s0_last;
   ifq_slot_t s0, s1;
   logic      unused_fields;

   assign unused_fields = ^{head_nxt.inst1, head_nxt.badv, head_nxt.excp};

   always_comb begin
      head_pair = entry_is_pair(head);
      nxt_pair  = entry_is_pair(head_nxt);
      head_excp = head.excp_flag != '0;
      nxt_excp  = head_nxt.excp_flag != '0;

      v0        = count != '0;
      // slot1 from the head's second half; implies the head has no exception
      from_head = !rd_half && head_pair;
      nxt_ok    = (count >= (LOG_DEPTH+1)'(2)) && !nxt_excp && !head_excp;
      v1        = v0 && (from_head || nxt_ok);

      s0.pc     = head.pc + (rd_half ? PC_W'(4) : PC_W'(0));
      s0.inst   = rd_half ? head.inst1 : head.inst0;
      s0_last   = rd_half || !head_pair;
      s0.pc_next = s0_last ? head.pc_next : s0.pc + PC_W'(4);
      s0.taken   = s0_last ? head.taken : 1'b0;

      if (from_head) begin
         s1.pc      = head.pc + PC_W'(4);
         s1.inst    = head.inst1;
         s1.pc_next = head.pc_next;
         s1.taken   = head.taken;
      end else begin
         s1.pc      = head_nxt.pc;
         s1.inst    = head_nxt.inst0;
         s1.pc_next = nxt_pair ? head_nxt.pc + PC_W'(4) : head_nxt.pc_next;
         s1.taken   = nxt_pair ? 1'b0 : head_nxt.taken;
      end

      // Idle slots present a NOP with zeroed fields rather than stale storage
      slot0            = v0 ? s0 : SLOT_IDLE;
      slot1            = v1 ? s1 : SLOT_IDLE;
      slot0_badv       = v0 ? head.badv : '0;
      slot0_excp       = v0 ? head.excp : '0;
      slot0_excp_valid = v0 && head_excp;
      out_valid        = {v1, v0};

      if (from_head) begin
         rd_inc_one  = 2'd0;
         rd_half_one = 1'b1;
      end else begin
         rd_inc_one  = 2'd1;
         rd_half_one = 1'b0;
      end

      if (from_head) begin
         rd_inc_two  = 2'd1;
         rd_half_two = 1'b0;
      end else if (nxt_pair) begin
         rd_inc_two  = 2'd1;
         rd_half_two = 1'b1;
      end else begin
         rd_inc_two  = 2'd2;
         rd_half_two = 1'b0;
      end
   end

endmodule

// File: rtl/inst_queue_issue.sv
// inst_queue_issue: consumer end of the fetch-to-decode instruction queue.
// Stores IF1 fetch packets in a DEPTH-entry circular buffer and presents a
// flattened two-slot instruction stream to decode.
// Ports: clk/rstn (async active-low), flush; IF1 push side in_* with
//        in_ready, space_ok, nearly_full back-pressure; decode side out_*
//        slot bundles with out_valid, and dec_accept (00/01/11).
module inst_queue_issue
   import inst_queue_issue_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned LOG_DEPTH = 3,
   parameter int unsigned SPACE_TH  = 3
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_W-1:0]        in_pc,
   input  logic [PC_W-1:0]        in_pc_next,
   input  logic                   in_taken,
   input  logic [INST_W-1:0]      in_inst0,
   input  logic [INST_W-1:0]      in_inst1,
   input  logic [PC_W-1:0]        in_badv,
   input  logic [EXCP_W-1:0]      in_excp,
   input  logic [EXCP_FLAG_W-1:0] in_excp_flag,
   output logic                   space_ok,
   output logic                   nearly_full,
   output logic [1:0]             out_valid,
   output logic [PC_W-1:0]        out_pc0,
   output logic [PC_W-1:0]        out_pc1,
   output logic [PC_W-1:0]        out_pc_next0,
   output logic [PC_W-1:0]        out_pc_next1,
   output logic                   out_taken0,
   output logic                   out_taken1,
   output logic [INST_W-1:0]      out_inst0,
   output logic [INST_W-1:0]      out_inst1,
   output logic [PC_W-1:0]        out_badv0,
   output logic [EXCP_W-1:0]      out_excp0,
   output logic                   out_excp_valid0,
   input  logic [1:0]             dec_accept
);

   typedef logic [LOG_DEPTH:0] ptr_t;

   ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic       rd_half_q, rd_half_d;
   ifq_entry_t mem_q [DEPTH];
   ifq_entry_t mem_d [DEPTH];

   ptr_t                 count, free;
   logic [LOG_DEPTH-1:0] wr_idx, rd_idx, rd_idx_nxt;
   ifq_entry_t           head, head_nxt, in_entry;
   ifq_slot_t            slot0, slot1;
   logic                 push;
   logic [1:0]           rd_inc_one, rd_inc_two;
   logic                 rd_half_one, rd_half_two;

   always_comb begin
      count       = wr_ptr_q - rd_ptr_q;
      free        = ptr_t'(DEPTH) - count;
      in_ready    = count != ptr_t'(DEPTH);
      space_ok    = free >= ptr_t'(SPACE_TH);
      nearly_full = free <= ptr_t'(1);
      wr_idx      = wr_ptr_q[LOG_DEPTH-1:0];
      rd_idx      = rd_ptr_q[LOG_DEPTH-1:0];
      rd_idx_nxt  = rd_idx + LOG_DEPTH'(1);
      head        = mem_q[rd_idx];
      head_nxt    = mem_q[rd_idx_nxt];
      push        = in_valid && in_ready && !flush;
      in_entry    = '{pc: in_pc, pc_next: in_pc_next, taken: in_taken,
                      inst0: in_inst0, inst1: in_inst1, badv: in_badv,
                      excp: in_excp, excp_flag: in_excp_flag};
   end

   ifq_slot_pick #(
      .LOG_DEPTH (LOG_DEPTH)
   ) u_slot_pick (
      .head             (head),
      .head_nxt         (head_nxt),
      .rd_half          (rd_half_q),
      .count            (count),
      .slot0            (slot0),
      .slot1            (slot1),
      .slot0_badv       (out_badv0),
      .slot0_excp       (out_excp0),
      .slot0_excp_valid (out_excp_valid0),
      .out_valid        (out_valid),
      .rd_inc_one       (rd_inc_one),
      .rd_half_one      (rd_half_one),
      .rd_inc_two       (rd_inc_two),
      .rd_half_two      (rd_half_two)
   );

   always_comb begin
      out_pc0      = slot0.pc;
      out_pc_next0 = slot0.pc_next;
      out_taken0   = slot0.taken;
      out_inst0    = slot0.inst;
      out_pc1      = slot1.pc;
      out_pc_next1 = slot1.pc_next;
      out_taken1   = slot1.taken;
      out_inst1    = slot1.inst;
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_half_d = rd_half_q;
      mem_d     = mem_q;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         rd_half_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_idx] = in_entry;
            wr_ptr_d      = wr_ptr_q + ptr_t'(1);
         end
         case (dec_accept)
            ACC_ONE: begin
               rd_ptr_d  = rd_ptr_q + ptr_t'(rd_inc_one);
               rd_half_d = rd_half_one;
            end
            ACC_TWO: begin
               rd_ptr_d  = rd_ptr_q + ptr_t'(rd_inc_two);
               rd_half_d = rd_half_two;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_half_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= ENTRY_RESET;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_half_q <= rd_half_d;
         mem_q     <= mem_d;
      end
   end

   accept_legal_a: assert property (@(posedge clk) disable iff (!rstn)
      (dec_accept != 2'b10) && ((dec_accept & ~out_valid) == 2'b00));

endmodule

// File: tb/tb_inst_queue_issue.sv
module tb_inst_queue_issue;

   localparam logic [31:0] NOP = 32'h0340_0000;

   logic        clk = 1'b0;
   logic        rstn, flush, in_valid, in_ready, in_taken;
   logic [31:0] in_pc, in_pc_next, in_inst0, in_inst1, in_badv;
   logic [6:0]  in_excp;
   logic [1:0]  in_excp_flag;
   logic        space_ok, nearly_full;
   logic [1:0]  out_valid, dec_accept;
   logic [31:0] out_pc0, out_pc1, out_pc_next0, out_pc_next1, out_inst0, out_inst1, out_badv0;
   logic        out_taken0, out_taken1, out_excp_valid0;
   logic [6:0]  out_excp0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   inst_queue_issue #(
      .DEPTH     (8),
      .LOG_DEPTH (3),
      .SPACE_TH  (3)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_pc           (in_pc),
      .in_pc_next      (in_pc_next),
      .in_taken        (in_taken),
      .in_inst0        (in_inst0),
      .in_inst1        (in_inst1),
      .in_badv         (in_badv),
      .in_excp         (in_excp),
      .in_excp_flag    (in_excp_flag),
      .space_ok        (space_ok),
      .nearly_full     (nearly_full),
      .out_valid       (out_valid),
      .out_pc0         (out_pc0),
      .out_pc1         (out_pc1),
      .out_pc_next0    (out_pc_next0),
      .out_pc_next1    (out_pc_next1),
      .out_taken0      (out_taken0),
      .out_taken1      (out_taken1),
      .out_inst0       (out_inst0),
      .out_inst1       (out_inst1),
      .out_badv0       (out_badv0),
      .out_excp0       (out_excp0),
      .out_excp_valid0 (out_excp_valid0),
      .dec_accept      (dec_accept)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] pc_next, input logic taken,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] badv,
                       input logic [6:0] excp, input logic [1:0] flag);
      in_pc = pc; in_pc_next = pc_next; in_taken = taken;
      in_inst0 = i0; in_inst1 = i1; in_badv = badv;
      in_excp = excp; in_excp_flag = flag;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic accept(input logic [1:0] acc);
      dec_accept = acc;
      cyc();
      dec_accept = 2'b00;
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_taken = 1'b0;
      in_pc = '0; in_pc_next = '0; in_inst0 = '0; in_inst1 = '0; in_badv = '0;
      in_excp = '0; in_excp_flag = '0; dec_accept = 2'b00;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      cyc();

      // 1: reset state
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_space_ok", 32'(space_ok), 32'd1);
      chk("rst_nearly_full", 32'(nearly_full), 32'd0);
      chk("rst_inst0", out_inst0, NOP);
      chk("rst_pc0", out_pc0, 32'd0);

      // 2: one two-instruction packet, taken at its end
      push(32'h1C000000, 32'h1C000008, 1'b1, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 7'h0, 2'b00);
      chk("t2_valid", 32'(out_valid), 32'd3);
      chk("t2_pc0", out_pc0, 32'h1C000000);
      chk("t2_inst0", out_inst0, 32'hAAAA0001);
      chk("t2_pcn0", out_pc_next0, 32'h1C000004);
      chk("t2_taken0", 32'(out_taken0), 32'd0);
      chk("t2_pc1", out_pc1, 32'h1C000004);
      chk("t2_inst1", out_inst1, 32'hBBBB0002);
      chk("t2_pcn1", out_pc_next1, 32'h1C000008);
      chk("t2_taken1", 32'(out_taken1), 32'd1);
      accept(2'b11);
      chk("t2_drained", 32'(out_valid), 32'd0);

      // 3: single packet then pair, slot1 pulled from the next entry
      push(32'h1C00000C, 32'h1C000010, 1'b0, 32'hCCCC0003, NOP, 32'h0, 7'h0, 2'b00);
      push(32'h1C000010, 32'h1C000018, 1'b0, 32'hDDDD0004, 32'hEEEE0005, 32'h0, 7'h0, 2'b00);
      chk("t3_valid", 32'(out_valid), 32'd3);
      chk("t3_pc0", out_pc0, 32'h1C00000C);
      chk("t3_inst0", out_inst0, 32'hCCCC0003);
      chk("t3_pcn0", out_pc_next0, 32'h1C000010);
      chk("t3_pc1", out_pc1, 32'h1C000010);
      chk("t3_inst1", out_inst1, 32'hDDDD0004);
      chk("t3_pcn1", out_pc_next1, 32'h1C000014);
      accept(2'b11);
      chk("t3_half_valid", 32'(out_valid), 32'd1);
      chk("t3_half_pc0", out_pc0, 32'h1C000014);
      chk("t3_half_inst0", out_inst0, 32'hEEEE0005);
      chk("t3_half_pcn0", out_pc_next0, 32'h1C000018);
      accept(2'b01);
      chk("t3_drained", 32'(out_valid), 32'd0);

      // 4: exception packet issues alone
      push(32'h1C000020, 32'h1C000028, 1'b0, 32'hF0F00006, 32'hF1F10007, 32'h1C000020, 7'h08, 2'b11);
      push(32'h1C000028, 32'h1C000030, 1'b0, 32'h12340008, 32'h56780009, 32'h0, 7'h0, 2'b00);
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_excp_valid", 32'(out_excp_valid0), 32'd1);
      chk("t4_excp", 32'(out_excp0), 32'h08);
      chk("t4_badv", out_badv0, 32'h1C000020);
      chk("t4_pc0", out_pc0, 32'h1C000020);
      accept(2'b01);
      chk("t4_next_valid", 32'(out_valid), 32'd3);
      chk("t4_next_excp_valid", 32'(out_excp_valid0), 32'd0);
      chk("t4_next_pc0", out_pc0, 32'h1C000028);
      chk("t4_next_inst1", out_inst1, 32'h56780009);
      accept(2'b11);
      chk("t4_drained", 32'(out_valid), 32'd0);

      // 5: fill to full (pointers wrap), then push+pop while full
      for (int k = 0; k < 8; k++) begin
         push(32'h1C001000 + 32'(8*k), 32'h1C001008 + 32'(8*k), 1'b0,
              32'hA0000000 + 32'(k), 32'hB0000000 + 32'(k), 32'h0, 7'h0, 2'b00);
         chk($sformatf("t5_in_ready_%0d", k+1), 32'(in_ready), 32'((k+1) != 8));
         chk($sformatf("t5_space_ok_%0d", k+1), 32'(space_ok), 32'((8-(k+1)) >= 3));
         chk($sformatf("t5_nearly_full_%0d", k+1), 32'(nearly_full), 32'((8-(k+1)) <= 1));
      end
      chk("t5_full_pc0", out_pc0, 32'h1C001000);
      in_pc = 32'h1C00E000; in_pc_next = 32'h1C00E008; in_inst0 = 32'hDEAD0000; in_inst1 = 32'hDEAD0001;
      in_valid = 1'b1; dec_accept = 2'b11;
      cyc();
      in_valid = 1'b0; dec_accept = 2'b00;
      chk("t5_pp_in_ready", 32'(in_ready), 32'd1);
      chk("t5_pp_nearly_full", 32'(nearly_full), 32'd1);
      chk("t5_pp_space_ok", 32'(space_ok), 32'd0);
      chk("t5_pp_pc0", out_pc0, 32'h1C001008);

      // 6: drain to four entries, then flush with a concurrent push
      repeat (3) accept(2'b11);
      chk("t6_pre_space_ok", 32'(space_ok), 32'd1);
      chk("t6_pre_nearly_full", 32'(nearly_full), 32'd0);
      chk("t6_pre_pc0", out_pc0, 32'h1C001020);
      in_pc = 32'h1C00F000; in_pc_next = 32'h1C00F008; in_inst0 = 32'hBAD00000; in_inst1 = 32'hBAD00001;
      in_valid = 1'b1; flush = 1'b1;
      cyc();
      in_valid = 1'b0; flush = 1'b0;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      chk("t6_space_ok", 32'(space_ok), 32'd1);
      chk("t6_nearly_full", 32'(nearly_full), 32'd0);
      cyc();
      chk("t6_still_empty", 32'(out_valid), 32'd0);
      push(32'h1C002000, 32'h1C002008, 1'b0, 32'h77770001, 32'h77770002, 32'h0, 7'h0, 2'b00);
      chk("t6_refill_valid", 32'(out_valid), 32'd3);
      chk("t6_refill_pc0", out_pc0, 32'h1C002000);
      chk("t6_refill_inst0", out_inst0, 32'h77770001);
      chk("t6_refill_pc1", out_pc1, 32'h1C002004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
